// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the parametrised MIPS inter-stage pipeline register.
//   pipe_state_t : holding state of a stage (EMPTY / HALF / FULL); the
//                  encoding equals the number of entries held, so it can be
//                  driven straight onto the occupancy port.
//   PIPE_NOP     : all-zero instruction word; a cleared payload decodes as
//                  this NOP in the instruction field.
//   PIPE_OCC_W   : width of the occupancy port.
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam logic [31:0] PIPE_NOP   = 32'h0000_0000;
    localparam int          PIPE_OCC_W = 2;

endpackage

// File: rtl/pipe_data_reg.sv
// ---------------------------------------------------------------------------
// pipe_data_reg
// DATA_W-bit payload register with load enable and synchronous clear.
// Clear beats enable; reset value is zero (the PIPE_NOP pattern).
// Ports:
//   clk    in           rising-edge clock
//   rst_n  in           asynchronous active-low reset
//   i_en   in           load i_d on the next edge
//   i_clr  in           load zero on the next edge (wins over i_en)
//   i_d    in  DATA_W   data to load
//   o_q    out DATA_W   held data
// ---------------------------------------------------------------------------
module pipe_data_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_clr)
            r_q <= '0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register with valid/ready handshake, synchronous
// flush and an optional skid slot. The payload is opaque: the instantiating
// stage packs pc_4, instruction, operands and control into in_data.
//
// Build option:
//   PIPE_STAGE_SKID_EN defined   : main + skid register, states
//                                  EMPTY/HALF/FULL, in_ready is a registered
//                                  decode (no path from out_ready).
//   PIPE_STAGE_SKID_EN undefined : main register only, states EMPTY/HALF,
//                                  in_ready = !out_valid | out_ready
//                                  (combinational), occupancy[1] = 0.
//
// Parameters:
//   DATA_W      payload width (>= 1)
//   CLEAR_DATA  1: flush also zeroes the payload registers; 0: flush only
//               drops the valid state and the data is left in place.
// Ports:
//   clk        in           rising-edge clock
//   rst_n      in           asynchronous active-low reset
//   flush      in           synchronous squash of all held entries
//   in_valid   in           upstream offers in_data
//   in_ready   out          stage accepts a push this cycle
//   in_data    in  DATA_W   upstream payload
//   out_valid  out          out_data holds a live entry
//   out_ready  in           downstream consumes out_data this cycle
//   out_data   out DATA_W   head payload (main register)
//   occupancy  out 2        entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    pipe_state_t       r_state;
    logic              w_push;
    logic              w_pop;
    logic              w_main_en;
    logic              w_clr;
    logic [DATA_W-1:0] w_main_d;
    logic [DATA_W-1:0] w_main_q;

    // A flush with CLEAR_DATA=0 must not touch the payload, so the enables
    // below are also gated by flush.
    assign w_clr = flush & CLEAR_DATA;

`ifdef PIPE_STAGE_SKID_EN

    pipe_state_t       w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              w_skid_en;
    logic [DATA_W-1:0] w_skid_q;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_en   = 1'b0;
        w_skid_en   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_nxt = HALF;
                    w_main_en   = 1'b1;
                end
            end
            HALF: begin
                if (w_push && w_pop) begin
                    w_main_en = 1'b1;
                end else if (w_push) begin
                    // Downstream stalled: park the new word behind main.
                    w_state_nxt = FULL;
                    w_skid_en   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_state_nxt = HALF;
                    w_main_en   = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_en   = 1'b0;
            w_skid_en   = 1'b0;
        end
    end

    // Main refills from skid when draining FULL, otherwise from upstream.
    assign w_main_d = (r_state == FULL) ? w_skid_q : in_data;

    // in_ready/out_valid are decoded from the next state and registered so
    // that in_ready has no combinational dependence on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != FULL);
            r_out_valid <= (w_state_nxt != EMPTY);
        end
    end

    pipe_data_reg #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_skid_en),
        .i_clr (w_clr),
        .i_d   (in_data),
        .o_q   (w_skid_q)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign occupancy = r_state;     // encoding equals entry count

`else

    // Single register: a push is accepted whenever the held word leaves in
    // the same cycle, which costs a combinational out_ready -> in_ready path.
    assign out_valid = (r_state == HALF);
    assign in_ready  = !out_valid | out_ready;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_main_en = w_push & !flush;
    assign w_main_d  = in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= EMPTY;
        else if (flush)
            r_state <= EMPTY;
        else if (w_push)
            r_state <= HALF;
        else if (w_pop)
            r_state <= EMPTY;
    end

    assign occupancy = {1'b0, (r_state == HALF)};

`endif

    pipe_data_reg #(.DATA_W(DATA_W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_main_en),
        .i_clr (w_clr),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    assign out_data = w_main_q;

endmodule
